// File: rtl/schoolbook_div.sv
// schoolbook_div: restoring shift-subtract divider, one quotient bit per clock, MSB first
module schoolbook_div #(
  parameter int WIDTH_N = 1142,
  parameter int WIDTH_D = 571
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH_N-1:0] n,
  input  logic [WIDTH_D-1:0] d,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_N-1:0] q,
  output logic [WIDTH_D-1:0] r,
  output logic               div_by_zero
);
  localparam int CW = $clog2(WIDTH_N + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH_N - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t             state;
  logic [WIDTH_N-1:0] n_sh;
  logic [WIDTH_N-1:0] q_acc;
  logic [WIDTH_D-1:0] d_reg;
  logic [WIDTH_D:0]   rem;
  logic [CW-1:0]      count;
  logic [WIDTH_D:0]   t;
  logic               ge;
  logic [WIDTH_D:0]   rem_nx;
  logic [WIDTH_N-1:0] q_nx;
  logic               unused_rem_msb;
  assign busy = (state == RUN);
  // one restoring step: bring down the next dividend bit and subtract if it fits
  always_comb begin
    t      = {rem[WIDTH_D-1:0], n_sh[WIDTH_N-1]};
    ge     = t >= {1'b0, d_reg};
    rem_nx = ge ? t - {1'b0, d_reg} : t;
    q_nx   = {q_acc[WIDTH_N-2:0], ge};
  end
  // rem stays below d_reg, so its top bit is always zero and never feeds the datapath
  assign unused_rem_msb = ^{rem[WIDTH_D], rem_nx[WIDTH_D]};
  // control FSM and datapath; results are only updated at completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      n_sh        <= '0;
      d_reg       <= '0;
      rem         <= '0;
      q_acc       <= '0;
      count       <= '0;
      done        <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && d == '0) begin
          q           <= '1;
          r           <= '0;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
        end else if (start) begin
          n_sh  <= n;
          d_reg <= d;
          rem   <= '0;
          q_acc <= '0;
          count <= '0;
          state <= RUN;
        end
      end else begin
        rem   <= rem_nx;
        q_acc <= q_nx;
        n_sh  <= n_sh << 1;
        count <= count + 1'b1;
        if (count == LAST) begin
          state       <= IDLE;
          q           <= q_nx;
          r           <= rem_nx[WIDTH_D-1:0];
          div_by_zero <= 1'b0;
          done        <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_schoolbook_div.sv
// tb_schoolbook_div: checks the divider against an arithmetic model and hand-computed results
module tb_schoolbook_div;
  localparam int BW = 1142;
  localparam int BD = 571;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sstart = 1'b0;
  logic [7:0] sn = '0;
  logic [3:0] sd = '0;
  logic sbusy, sdone, sdz;
  logic [7:0] sq;
  logic [3:0] sr;
  logic bstart = 1'b0;
  logic [BW-1:0] bn = '0;
  logic [BD-1:0] bd = '0;
  logic bbusy, bdone, bdz;
  logic [BW-1:0] bq;
  logic [BD-1:0] br;
  int checks = 0;
  int errors = 0;
  schoolbook_div #(.WIDTH_N(8), .WIDTH_D(4)) dut_s (
    .clk(clk), .rst(rst), .start(sstart), .n(sn), .d(sd),
    .busy(sbusy), .done(sdone), .q(sq), .r(sr), .div_by_zero(sdz)
  );
  schoolbook_div dut_b (
    .clk(clk), .rst(rst), .start(bstart), .n(bn), .d(bd),
    .busy(bbusy), .done(bdone), .q(bq), .r(br), .div_by_zero(bdz)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // model of the small instance: a countdown plus plain division
  int m_left = 0;
  logic m_done = 1'b0, m_dz = 1'b0;
  logic [7:0] m_q = '0, m_pq = '0;
  logic [3:0] m_r = '0, m_pr = '0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left <= 0; m_done <= 1'b0; m_q <= '0; m_r <= '0; m_dz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1; m_q <= m_pq; m_r <= m_pr; m_dz <= 1'b0;
        end
      end else if (sstart) begin
        if (sd == 4'd0) begin
          m_done <= 1'b1; m_q <= 8'hFF; m_r <= '0; m_dz <= 1'b1;
        end else begin
          m_left <= 8;
          m_pq <= sn / {4'd0, sd};
          m_pr <= 4'(sn % {4'd0, sd});
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    chk("mon_busy", BW'(sbusy), BW'(m_left != 0));
    chk("mon_done", BW'(sdone), BW'(m_done));
    chk("mon_q", BW'(sq), BW'(m_q));
    chk("mon_r", BW'(sr), BW'(m_r));
    chk("mon_dz", BW'(sdz), BW'(m_dz));
  end
  task automatic go_s(input logic [7:0] nn, input logic [3:0] dd);
    sstart = 1'b1; sn = nn; sd = dd;
    @(posedge clk); #1;
    sstart = 1'b0;
  endtask
  task automatic wait_s(output int bc);
    logic got = 1'b0;
    bc = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (sdone) got = 1'b1;
      else if (sbusy) bc++;
    end
    chk("s_timeout", BW'(got), BW'(1'b1));
  endtask
  task automatic run_s(input string nm, input logic [7:0] nn, input logic [3:0] dd,
                       input logic [7:0] eq, input logic [3:0] er, input logic edz, input int ebc);
    int bc;
    go_s(nn, dd);
    wait_s(bc);
    chk({nm, "_busy_cycles"}, BW'(bc), BW'(ebc));
    chk({nm, "_q"}, BW'(sq), BW'(eq));
    chk({nm, "_r"}, BW'(sr), BW'(er));
    chk({nm, "_dz"}, BW'(sdz), BW'(edz));
    #1;
  endtask
  task automatic rnd(output logic [BD-1:0] v);
    logic [575:0] tmp;
    for (int i = 0; i < 18; i++) tmp[i*32 +: 32] = $urandom;
    v = tmp[BD-1:0];
  endtask
  task automatic run_b(input string nm, input logic [BW-1:0] nn, input logic [BD-1:0] dd,
                       input logic [BW-1:0] eq, input logic [BD-1:0] er);
    int bc = 0;
    logic got = 1'b0;
    bstart = 1'b1; bn = nn; bd = dd;
    @(posedge clk); #1;
    bstart = 1'b0;
    for (int i = 0; i < 1300 && !got; i++) begin
      @(negedge clk);
      if (bdone) got = 1'b1;
      else if (bbusy) bc++;
    end
    chk({nm, "_timeout"}, BW'(got), BW'(1'b1));
    chk({nm, "_busy_cycles"}, BW'(bc), BW'(1142));
    chk({nm, "_q"}, bq, eq);
    chk({nm, "_r"}, BW'(br), BW'(er));
    chk({nm, "_dz"}, BW'(bdz), BW'(1'b0));
    #1;
  endtask
  initial begin
    int bc;
    logic [BD-1:0] a, b, k;
    logic [BW-1:0] prod;
    @(negedge clk);
    chk("rst_busy", BW'(sbusy), BW'(1'b0));
    chk("rst_done", BW'(sdone), BW'(1'b0));
    chk("rst_q", BW'(sq), BW'(8'd0));
    chk("rst_r", BW'(sr), BW'(4'd0));
    #1 rst = 1'b1;
    @(negedge clk); #1;
    run_s("d100_7", 8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 8);
    run_s("d255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8);
    run_s("d5_15", 8'd5, 4'd15, 8'd0, 4'd5, 1'b0, 8);
    run_s("dzero", 8'hA5, 4'd0, 8'hFF, 4'd0, 1'b1, 0);
    run_s("d9_3", 8'd9, 4'd3, 8'd3, 4'd0, 1'b0, 8);
    go_s(8'd100, 4'd7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      sstart = 1'b1; sn = 8'd1; sd = 4'd1;
    end
    @(negedge clk); #1;
    sstart = 1'b0;
    wait_s(bc);
    chk("ign_q", BW'(sq), BW'(8'd14));
    chk("ign_r", BW'(sr), BW'(4'd2));
    #1;
    sstart = 1'b1; sn = 8'd100; sd = 4'd7;
    @(posedge clk); #1;
    sn = 8'd200; sd = 4'd9;
    wait_s(bc);
    chk("held_first_q", BW'(sq), BW'(8'd14));
    @(posedge clk); #1;
    sstart = 1'b0;
    @(negedge clk);
    chk("held_launch_busy", BW'(sbusy), BW'(1'b1));
    wait_s(bc);
    chk("held_q", BW'(sq), BW'(8'd22));
    chk("held_r", BW'(sr), BW'(4'd2));
    #1;
    go_s(8'd100, 4'd7);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy", BW'(sbusy), BW'(1'b0));
    chk("arst_done", BW'(sdone), BW'(1'b0));
    chk("arst_q", BW'(sq), BW'(8'd0));
    chk("arst_r", BW'(sr), BW'(4'd0));
    chk("arst_dz", BW'(sdz), BW'(1'b0));
    #1 rst = 1'b1;
    @(negedge clk); #1;
    run_s("d200_9", 8'd200, 4'd9, 8'd22, 4'd2, 1'b0, 8);
    for (int i = 0; i < 2; i++) begin
      rnd(a); rnd(b); rnd(k);
      a[0] = 1'b1;
      k = k % a;
      prod = BW'(a) * BW'(b);
      run_b("big_exact", prod, a, BW'(b), '0);
      run_b("big_rem", prod + BW'(k), a, BW'(b), k);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
